// File: rtl/cmos_tx_pkg.sv
// Shared state encoding and default video timing for the CMOS byte transmitter.
package cmos_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_LINE,
    ST_HBLANK,
    ST_VFP
  } state_e;

  localparam int DEF_H_ACT    = 640;
  localparam int DEF_V_ACT    = 480;
  localparam int DEF_VS_WIDTH = 4;
  localparam int DEF_V_BP     = 16;
  localparam int DEF_H_BLANK  = 8;
  localparam int DEF_V_FP     = 16;

  // Largest of four timing values; sizes the shared blanking timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rgb565_byte_ser.sv
// Splits accepted RGB565 pixels into high/low bytes on a two-cycle slot.
module rgb565_byte_ser
  import cmos_tx_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        line_act_i,
  input  logic        s_valid_i,
  input  logic [15:0] s_data_i,
  output logic        phase_o,
  output logic [7:0]  pdata_o,
  output logic        de_o,
  output logic        underrun_o
);

  logic       phase_q, phase_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] pdata_q, pdata_d;
  logic       de_q, de_d;
  logic       underrun_q, underrun_d;

  // Next byte: high byte (or zero) on phase 0, held low byte on phase 1.
  always_comb begin
    phase_d    = 1'b0;
    hold_d     = hold_q;
    pdata_d    = '0;
    de_d       = line_act_i;
    underrun_d = 1'b0;
    if (line_act_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        underrun_d = ~s_valid_i;
        pdata_d    = s_valid_i ? s_data_i[15:8] : 8'h00;
        hold_d     = s_valid_i ? s_data_i[7:0]  : 8'h00;
      end else begin
        pdata_d = hold_q;
      end
    end
  end

  // Output and phase registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      hold_q     <= '0;
      pdata_q    <= '0;
      de_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      pdata_q    <= pdata_d;
      de_q       <= de_d;
      underrun_q <= underrun_d;
    end
  end

  assign phase_o    = phase_q;
  assign pdata_o    = pdata_q;
  assign de_o       = de_q;
  assign underrun_o = underrun_q;

endmodule

// File: rtl/cmos_16_8bit_tx.sv
// RGB565 to 8-bit CMOS parallel transmitter: frame timing FSM and counters.
module cmos_16_8bit_tx
  import cmos_tx_pkg::*;
#(
  parameter int H_ACT    = DEF_H_ACT,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int VS_WIDTH = DEF_VS_WIDTH,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        s_sof,
  output logic        s_ready,
  output logic        vs_o,
  output logic        de_o,
  output logic [7:0]  pdata_o,
  output logic        underrun_o,
  output logic        sof_err_o
);

  localparam int TW = $clog2(max4(VS_WIDTH, V_BP, H_BLANK, V_FP) + 1);
  localparam int PW = $clog2(H_ACT + 1);
  localparam int LW = $clog2(V_ACT + 1);

  localparam logic [TW-1:0] VS_LAST  = TW'(VS_WIDTH - 1);
  localparam logic [TW-1:0] VBP_LAST = TW'(V_BP - 1);
  localparam logic [TW-1:0] HB_LAST  = TW'(H_BLANK - 1);
  localparam logic [TW-1:0] VFP_LAST = TW'(V_FP - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(H_ACT - 1);
  localparam logic [LW-1:0] LN_LAST  = LW'(V_ACT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic          vs_q;
  logic          sof_err_q, sof_err_d;
  logic          first_q, first_d;
  logic          phase;
  logic          line_act;
  logic          accept;
  logic          vs_entry;

  assign line_act = (state_q == ST_LINE);
  assign s_ready  = line_act && !phase && !rst;
  assign accept   = s_valid && s_ready;

  // Next state, timers, pixel/line counters and framing-error tracking.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 1'b1;
    pix_d     = pix_q;
    line_d    = line_q;
    sof_err_d = sof_err_q;
    first_d   = first_q;
    unique case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (en) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (tmr_q == VS_LAST) begin
          state_d = ST_VBP;
          tmr_d   = '0;
        end
      end
      ST_VBP: begin
        if (tmr_q == VBP_LAST) begin
          state_d = ST_LINE;
          tmr_d   = '0;
        end
      end
      ST_LINE: begin
        tmr_d = '0;
        if (phase) begin
          pix_d = pix_q + 1'b1;
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            line_d  = line_q + 1'b1;
            state_d = (line_q == LN_LAST) ? ST_VFP : ST_HBLANK;
          end
        end
      end
      ST_HBLANK: begin
        if (tmr_q == HB_LAST) begin
          state_d = ST_LINE;
          tmr_d   = '0;
        end
      end
      ST_VFP: begin
        if (tmr_q == VFP_LAST) begin
          state_d = en ? ST_VSYNC : ST_IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase

    if (vs_entry) begin
      tmr_d     = '0;
      pix_d     = '0;
      line_d    = '0;
      sof_err_d = 1'b0;
      first_d   = 1'b1;
    end else if (accept) begin
      if (first_q ? !s_sof : s_sof) sof_err_d = 1'b1;
      first_d = 1'b0;
    end
  end

  assign vs_entry = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);

  // State, counter and flag registers; vs_o registered from next state so it aligns with state.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      vs_q      <= 1'b0;
      sof_err_q <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      vs_q      <= (state_d == ST_VSYNC);
      sof_err_q <= sof_err_d;
      first_q   <= first_d;
    end
  end

  rgb565_byte_ser u_ser (
    .pclk       (pclk),
    .rst        (rst),
    .line_act_i (line_act),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .phase_o    (phase),
    .pdata_o    (pdata_o),
    .de_o       (de_o),
    .underrun_o (underrun_o)
  );

  assign vs_o      = vs_q;
  assign sof_err_o = sof_err_q;

endmodule

// File: tb/tb_cmos_16_8bit_tx.sv
// Directed/randomized frame-level bench for cmos_16_8bit_tx with a timeline reference model.
module tb_cmos_16_8bit_tx;

  localparam int H_ACT   = 2;
  localparam int V_ACT   = 2;
  localparam int VS_W    = 2;
  localparam int VBP     = 1;
  localparam int HB      = 2;
  localparam int VFP     = 1;
  localparam int NPIX    = H_ACT * V_ACT;
  localparam int LSTRIDE = 2 * H_ACT + HB;
  localparam int FRAME   = VS_W + VBP + V_ACT * 2 * H_ACT + (V_ACT - 1) * HB + VFP;

  logic        pclk = 1'b0;
  logic        rst, en, s_valid, s_sof;
  logic [15:0] s_data;
  logic        s_ready, vs_o, de_o, underrun_o, sof_err_o;
  logic [7:0]  pdata_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] pix   [NPIX];
  logic        vmask [NPIX];
  logic        smask [NPIX];

  logic        exp_de, exp_ur, exp_err, first;
  logic [7:0]  exp_pd, low;

  always #5 pclk = ~pclk;

  cmos_16_8bit_tx #(
    .H_ACT    (H_ACT),
    .V_ACT    (V_ACT),
    .VS_WIDTH (VS_W),
    .V_BP     (VBP),
    .H_BLANK  (HB),
    .V_FP     (VFP)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .en         (en),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .vs_o       (vs_o),
    .de_o       (de_o),
    .pdata_o    (pdata_o),
    .underrun_o (underrun_o),
    .sof_err_o  (sof_err_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  // Byte index within the active line for a frame offset, or -1 outside lines.
  function automatic int line_byte(input int o);
    int s;
    for (int l = 0; l < V_ACT; l++) begin
      s = VS_W + VBP + l * LSTRIDE;
      if (o >= s && o < s + 2 * H_ACT) return o - s;
    end
    return -1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_vs", vs_o, 1'b0);
      chk("idle_de", de_o, 1'b0);
      chk("idle_pdata", pdata_o, 8'h00);
      chk("idle_ready", s_ready, 1'b0);
      chk("idle_underrun", underrun_o, 1'b0);
      chk("idle_sof_err", sof_err_o, exp_err);
      s_valid = 1'(($urandom_range(0, 1)));
      s_data  = 16'($urandom);
      cyc();
    end
  endtask

  // Called right after the edge that entered VSYNC; runs one frame timeline.
  task automatic frame(input int rst_at, input int en_drop_at);
    int b, p;
    exp_de = 1'b0; exp_pd = 8'h00; exp_ur = 1'b0; exp_err = 1'b0; first = 1'b1; low = 8'h00;
    for (int o = 0; o < FRAME; o++) begin
      b = line_byte(o);
      chk("vs_o", vs_o, 16'(o < VS_W));
      chk("de_o", de_o, exp_de);
      chk("pdata_o", pdata_o, exp_pd);
      chk("underrun_o", underrun_o, exp_ur);
      chk("sof_err_o", sof_err_o, exp_err);
      chk("s_ready", s_ready, 16'(b >= 0 && b % 2 == 0));
      en = (o < en_drop_at);
      if (b >= 0 && b % 2 == 0) begin
        p       = ((o - VS_W - VBP) / LSTRIDE) * H_ACT + b / 2;
        s_valid = vmask[p];
        s_data  = pix[p];
        s_sof   = smask[p];
      end else begin
        s_valid = 1'(($urandom_range(0, 1)));
        s_data  = 16'($urandom);
        s_sof   = 1'(($urandom_range(0, 1)));
      end
      exp_de = (b >= 0);
      exp_ur = 1'b0;
      if (b < 0) begin
        exp_pd = 8'h00;
      end else if (b % 2 == 0) begin
        exp_ur = !s_valid;
        exp_pd = s_valid ? s_data[15:8] : 8'h00;
        low    = s_valid ? s_data[7:0] : 8'h00;
        if (s_valid) begin
          if (first ? !s_sof : s_sof) exp_err = 1'b1;
          first = 1'b0;
        end
      end else begin
        exp_pd = low;
      end
      if (o == rst_at) begin
        rst = 1'b1;
        #1;
        chk("s_ready_in_rst", s_ready, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_vs", vs_o, 1'b0);
        chk("rst_de", de_o, 1'b0);
        chk("rst_pdata", pdata_o, 8'h00);
        chk("rst_underrun", underrun_o, 1'b0);
        chk("rst_sof_err", sof_err_o, 1'b0);
        chk("rst_ready_after", s_ready, 1'b0);
        exp_err = 1'b0;
        cyc();
        return;
      end
      cyc();
    end
  endtask

  task automatic rand_pixels();
    for (int i = 0; i < NPIX; i++) begin
      pix[i]   = 16'($urandom);
      vmask[i] = ($urandom_range(0, 3) != 0);
      smask[i] = (i == 0) ^ ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
    exp_err = 1'b0;
    cyc();
    cyc();
    chk("reset_vs", vs_o, 1'b0);
    chk("reset_de", de_o, 1'b0);
    chk("reset_pdata", pdata_o, 8'h00);
    chk("reset_underrun", underrun_o, 1'b0);
    chk("reset_sof_err", sof_err_o, 1'b0);
    chk("reset_ready", s_ready, 1'b0);
    rst = 1'b0;
    cyc();
    idle(2);

    // Colour bars, all valid, sof on first pixel.
    pix[0] = 16'hF800; pix[1] = 16'h07E0; pix[2] = 16'h001F; pix[3] = 16'hFFFF;
    for (int i = 0; i < NPIX; i++) begin
      vmask[i] = 1'b1;
      smask[i] = (i == 0);
    end
    en = 1'b1;
    cyc();
    frame(-1, 99);

    // Missing second pixel of line 0.
    vmask[1] = 1'b0;
    frame(-1, 99);

    // Wrong sof placement: first pixel without, third pixel with.
    vmask[1] = 1'b1;
    smask[0] = 1'b0; smask[2] = 1'b1;
    frame(-1, 99);

    // Random frame, en dropped during line 1.
    rand_pixels();
    frame(-1, VS_W + VBP + LSTRIDE);
    idle(4);

    // Reset in the middle of line 0 after the F8 byte.
    pix[0] = 16'hF800; vmask[0] = 1'b1; smask[0] = 1'b1;
    en = 1'b1;
    cyc();
    frame(5, 99);

    // Back-to-back random frames, ending on a dropped en.
    for (int f = 0; f < 4; f++) begin
      rand_pixels();
      frame(-1, (f == 3) ? FRAME - 1 : 99);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
